// File: rtl/sr_task_queue_param.sv
// Priority task queue: cells kept sorted by ascending tid (equal tids FIFO),
// with remove-by-tid, head pop, and a saturating per-cell countdown on tick.
module sr_task_queue_param #(
    parameter  int DEPTH  = 8,
    parameter  int TID_W  = 4,
    parameter  int INFO_W = 32,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enq,
    input  logic [TID_W-1:0]  enq_tid,
    input  logic [INFO_W-1:0] enq_info,
    input  logic              deq,
    input  logic              rem,
    input  logic [TID_W-1:0]  rem_tid,
    input  logic              tick,
    input  logic              que_act,
    input  logic              que_blk,
    output logic [TID_W-1:0]  out_tid,
    output logic [INFO_W-1:0] info_out,
    output logic              empty_flag,
    output logic              full_flag,
    output logic              schden_flag,
    output logic [CW-1:0]     count
);

    // Requests are single-cycle strobes with no ready: each one is either
    // applied on the next rising edge or dropped (enq while full, deq while
    // empty, rem with no matching tid); rem wins over deq, deq over enq.

    logic              valid_q [DEPTH];
    logic [TID_W-1:0]  tid_q   [DEPTH];
    logic [INFO_W-1:0] info_q  [DEPTH];
    logic [CW-1:0]     count_q;
    logic              schden_q;

    // s_*: after the remove/pop shift; n_*: after insert and tick
    logic              s_v     [DEPTH];
    logic [TID_W-1:0]  s_tid   [DEPTH];
    logic [INFO_W-1:0] s_info  [DEPTH];
    logic              n_v     [DEPTH];
    logic [TID_W-1:0]  n_tid   [DEPTH];
    logic [INFO_W-1:0] n_info  [DEPTH];
    logic [CW-1:0]     n_count;
    logic              seen;
    logic              pop;
    logic              push;
    logic              shift;
    int                ins_pos;

    always_comb begin
        seen    = 1'b0;
        shift   = 1'b0;
        ins_pos = 0;
        n_count = '0;
        pop     = deq && !rem && (count_q != '0);
        push    = enq && !rem && (!full_flag || pop);

        // Close the gap at the first matching cell, or shift everything on a pop.
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (rem && valid_q[i] && tid_q[i] == rem_tid) seen = 1'b1;
            shift = rem ? seen : pop;
            if (shift) begin
                s_v[i]    = valid_q[i+1];
                s_tid[i]  = tid_q[i+1];
                s_info[i] = info_q[i+1];
            end else begin
                s_v[i]    = valid_q[i];
                s_tid[i]  = tid_q[i];
                s_info[i] = info_q[i];
            end
        end
        if (rem && valid_q[DEPTH-1] && tid_q[DEPTH-1] == rem_tid) seen = 1'b1;
        shift = rem ? seen : pop;
        if (shift) begin
            s_v[DEPTH-1]    = 1'b0;
            s_tid[DEPTH-1]  = '0;
            s_info[DEPTH-1] = '0;
        end else begin
            s_v[DEPTH-1]    = valid_q[DEPTH-1];
            s_tid[DEPTH-1]  = tid_q[DEPTH-1];
            s_info[DEPTH-1] = info_q[DEPTH-1];
        end

        // Insertion point sits behind every entry with tid <= enq_tid.
        for (int i = 0; i < DEPTH; i++) begin
            if (s_v[i] && s_tid[i] <= enq_tid) ins_pos = ins_pos + 1;
        end

        for (int i = 0; i < DEPTH; i++) begin
            n_v[i]    = s_v[i];
            n_tid[i]  = s_tid[i];
            n_info[i] = s_info[i];
            if (push && i == ins_pos) begin
                n_v[i]    = 1'b1;
                n_tid[i]  = enq_tid;
                n_info[i] = enq_info;
            end
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (push && i > ins_pos) begin
                n_v[i]    = s_v[i-1];
                n_tid[i]  = s_tid[i-1];
                n_info[i] = s_info[i-1];
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (tick && n_v[i] && !(push && i == ins_pos) && n_info[i] != '0)
                n_info[i] = n_info[i] - INFO_W'(1);
            if (n_v[i]) n_count = n_count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tid_q[i]   <= '0;
                info_q[i]  <= '0;
            end
            count_q  <= '0;
            schden_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= n_v[i];
                tid_q[i]   <= n_tid[i];
                info_q[i]  <= n_info[i];
            end
            count_q  <= n_count;
            schden_q <= que_act && !que_blk && (n_count != '0);
        end
    end

    // Vacated cells are always zeroed, so the head reads 0 when empty.
    assign out_tid     = tid_q[0];
    assign info_out    = info_q[0];
    assign count       = count_q;
    assign empty_flag  = (count_q == '0);
    assign full_flag   = (count_q == CW'(DEPTH));
    assign schden_flag = schden_q;

endmodule

// File: tb/tb_sr_task_queue_param.sv
// Directed bench for sr_task_queue_param (DEPTH=8, TID_W=4, INFO_W=32):
// sorted insert, full drop, saturating tick, remove precedence, schden, reset.
module tb_sr_task_queue_param;

    localparam int DEPTH  = 8;
    localparam int TID_W  = 4;
    localparam int INFO_W = 32;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enq;
    logic [TID_W-1:0]  enq_tid;
    logic [INFO_W-1:0] enq_info;
    logic              deq;
    logic              rem;
    logic [TID_W-1:0]  rem_tid;
    logic              tick;
    logic              que_act;
    logic              que_blk;
    logic [TID_W-1:0]  out_tid;
    logic [INFO_W-1:0] info_out;
    logic              empty_flag;
    logic              full_flag;
    logic              schden_flag;
    logic [CW-1:0]     count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [TID_W+INFO_W-1:0] exp_q[$];

    sr_task_queue_param #(.DEPTH(DEPTH), .TID_W(TID_W), .INFO_W(INFO_W)) dut (
        .clk(clk), .rst_n(rst_n), .enq(enq), .enq_tid(enq_tid), .enq_info(enq_info),
        .deq(deq), .rem(rem), .rem_tid(rem_tid), .tick(tick),
        .que_act(que_act), .que_blk(que_blk), .out_tid(out_tid), .info_out(info_out),
        .empty_flag(empty_flag), .full_flag(full_flag), .schden_flag(schden_flag),
        .count(count)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // driver: one cycle with the given strobes, sampled 1ns after the edge
    task automatic step(input logic e, input logic [TID_W-1:0] t, input logic [INFO_W-1:0] inf,
                        input logic d, input logic r, input logic [TID_W-1:0] rt, input logic tk);
        enq = e; enq_tid = t; enq_info = inf;
        deq = d; rem = r; rem_tid = rt; tick = tk;
        @(posedge clk);
        #1;
        enq = 1'b0; deq = 1'b0; rem = 1'b0; tick = 1'b0;
    endtask

    task automatic push_enq(input logic [TID_W-1:0] t, input logic [INFO_W-1:0] inf);
        step(1'b1, t, inf, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    // scoreboard: pop the DUT head by head against the expected queue
    task automatic drain(input string tag);
        logic [TID_W+INFO_W-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_tid"},  32'(out_tid),  32'(e[TID_W+INFO_W-1:INFO_W]));
            check({tag, "_info"}, 32'(info_out), 32'(e[INFO_W-1:0]));
            step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        end
        check({tag, "_empty"}, 32'(empty_flag), 32'd1);
        check({tag, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; enq = 1'b0; enq_tid = '0; enq_info = '0;
        deq = 1'b0; rem = 1'b0; rem_tid = '0; tick = 1'b0;
        que_act = 1'b0; que_blk = 1'b0;

        // reset state
        do_reset();
        check("rst_count",  32'(count), 32'd0);
        check("rst_empty",  32'(empty_flag), 32'd1);
        check("rst_full",   32'(full_flag), 32'd0);
        check("rst_schden", 32'(schden_flag), 32'd0);
        check("rst_tid",    32'(out_tid), 32'd0);
        check("rst_info",   info_out, 32'd0);

        // sorted insert, equal tids FIFO
        push_enq(4'd5, 32'd10);
        push_enq(4'd2, 32'd20);
        push_enq(4'd7, 32'd30);
        push_enq(4'd2, 32'd40);
        check("sort_count", 32'(count), 32'd4);
        check("sort_head_tid", 32'(out_tid), 32'd2);
        check("sort_head_info", info_out, 32'd20);
        exp_q = '{{4'd2, 32'd20}, {4'd2, 32'd40}, {4'd5, 32'd10}, {4'd7, 32'd30}};
        drain("sort");
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("deq_empty_count", 32'(count), 32'd0);

        // fill, drop when full, then enq+deq while full
        for (int t = 1; t <= DEPTH; t++) push_enq(TID_W'(t), INFO_W'(100 + t));
        check("fill_full", 32'(full_flag), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        push_enq(4'd0, 32'd99);
        check("drop_count", 32'(count), 32'd8);
        check("drop_head_tid", 32'(out_tid), 32'd1);
        check("drop_head_info", info_out, 32'd101);
        step(1'b1, 4'd4, 32'd55, 1'b1, 1'b0, '0, 1'b0);
        check("eqdq_count", 32'(count), 32'd8);
        check("eqdq_full", 32'(full_flag), 32'd1);
        exp_q = '{{4'd2, 32'd102}, {4'd3, 32'd103}, {4'd4, 32'd104}, {4'd4, 32'd55},
                  {4'd5, 32'd105}, {4'd6, 32'd106}, {4'd7, 32'd107}, {4'd8, 32'd108}};
        drain("full");

        // enq+deq on an empty queue: only the enqueue lands
        step(1'b1, 4'd9, 32'd1, 1'b1, 1'b0, '0, 1'b0);
        check("eqdq_empty_count", 32'(count), 32'd1);
        check("eqdq_empty_tid", 32'(out_tid), 32'd9);
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);

        // saturating countdown
        do_reset();
        push_enq(4'd1, 32'd3);
        push_enq(4'd4, 32'd0);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        check("tick1", info_out, 32'd2);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        check("tick2", info_out, 32'd1);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        check("tick3", info_out, 32'd0);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        check("tick4", info_out, 32'd0);
        check("tick_count", 32'(count), 32'd2);
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("tick_tail_tid", 32'(out_tid), 32'd4);
        check("tick_tail_info", info_out, 32'd0);
        step(1'b1, 4'd3, 32'd5, 1'b0, 1'b0, '0, 1'b1);
        exp_q = '{{4'd3, 32'd5}, {4'd4, 32'd0}};
        drain("tick_ins");

        // remove wins over deq; missing tid is a no-op
        do_reset();
        push_enq(4'd1, 32'd11);
        push_enq(4'd3, 32'd31);
        push_enq(4'd3, 32'd32);
        push_enq(4'd6, 32'd61);
        step(1'b0, '0, '0, 1'b1, 1'b1, 4'd3, 1'b0);
        check("rem_count", 32'(count), 32'd3);
        check("rem_head", 32'(out_tid), 32'd1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 4'd9, 1'b0);
        check("rem_miss_count", 32'(count), 32'd3);
        check("rem_miss_head", info_out, 32'd11);

        // schedule-enable flag
        que_act = 1'b1;
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        check("schden_on", 32'(schden_flag), 32'd1);
        que_blk = 1'b1;
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        check("schden_blk", 32'(schden_flag), 32'd0);
        que_blk = 1'b0;
        exp_q = '{{4'd1, 32'd11}, {4'd3, 32'd32}, {4'd6, 32'd61}};
        drain("rem");
        check("schden_drained", 32'(schden_flag), 32'd0);

        // reset overrides a same-cycle enqueue
        push_enq(4'd5, 32'd7);
        check("schden_refill", 32'(schden_flag), 32'd1);
        rst_n = 1'b0;
        step(1'b1, 4'd2, 32'd8, 1'b0, 1'b0, '0, 1'b1);
        check("rst_enq_count", 32'(count), 32'd0);
        check("rst_enq_empty", 32'(empty_flag), 32'd1);
        check("rst_enq_tid", 32'(out_tid), 32'd0);
        check("rst_enq_schden", 32'(schden_flag), 32'd0);
        rst_n = 1'b1;
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        check("post_rst_count", 32'(count), 32'd0);
        que_act = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_task_queue_param.md
SR_TASK_QUEUE_PARAM -- requirements
Module: sr_task_queue_param

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of queue cells (minimum 2).
REQ-002 The block SHALL have parameter TID_W, default 4, meaning the task-ID width; a lower value is a higher priority.
REQ-003 The block SHALL have parameter INFO_W, default 32, meaning the width of the per-task schedule info (countdown value).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port enq  input  1  request to insert {enq_tid, enq_info}.
REQ-007 The block SHALL have ports enq_tid  input  TID_W and enq_info  input  INFO_W, carrying the task to insert.
REQ-008 The block SHALL have port deq  input  1  request to pop the head cell.
REQ-009 The block SHALL have port rem  input  1  request to delete the entry matching rem_tid.
REQ-010 The block SHALL have port rem_tid  input  TID_W  the task ID to remove.
REQ-011 The block SHALL have port tick  input  1  countdown strobe for stored info.
REQ-012 The block SHALL have ports que_act and que_blk  input  1 each, giving the queue active and queue blocked status.
REQ-013 The block SHALL have ports out_tid  output  TID_W and info_out  output  INFO_W, carrying the head cell contents.
REQ-014 The block SHALL have ports empty_flag, full_flag and schden_flag  output  1 each, plus port count  output  $clog2(DEPTH+1), giving the occupied cell count.

Function
REQ-015 Storage SHALL be DEPTH cells, each holding {valid, tid, info}, kept sorted by ascending tid from cell 0 (head); valid cells SHALL be contiguous from cell 0.
REQ-016 Enqueue SHALL insert the new entry after all valid entries with tid <= enq_tid, so equal tids are served FIFO; cells behind the insertion point shift one place toward the tail; the result is visible the next cycle.
REQ-017 Enqueue while full_flag=1 SHALL be dropped, with no state change from the enq request.
REQ-018 Dequeue SHALL shift every cell one place toward the head; dequeue while empty SHALL be ignored.
REQ-019 Remove SHALL delete the first (closest-to-head) valid cell whose tid equals rem_tid and close the gap; if no cell matches, the request SHALL be a no-op.
REQ-020 Precedence within one cycle SHALL be rem, then deq, then enq: when rem=1, deq and enq SHALL be ignored.
REQ-021 When enq=1 and deq=1 together with the queue non-empty, both SHALL take effect; the pop applies first, so the queue never overflows and count is unchanged.
REQ-022 When enq=1 and deq=1 together with the queue empty, the enqueue alone SHALL take effect.
REQ-023 On tick=1, every valid cell not written by an insert that cycle SHALL decrement info by 1, saturating at 0 (no wrap).
REQ-024 The newly inserted entry SHALL store enq_info undecremented.
REQ-025 out_tid and info_out SHALL reflect cell 0 (registered state, no combinational path from inputs); when the queue is empty they SHALL be 0.
REQ-026 empty_flag SHALL equal (count==0).
REQ-027 full_flag SHALL equal (count==DEPTH).
REQ-028 count SHALL update in the same cycle as the cell contents.
REQ-029 schden_flag SHALL be registered, set to 1 when que_act=1, que_blk=0 and the queue is non-empty (evaluated on next-state occupancy), and 0 otherwise, including when que_act and que_blk are both 1.

Reset
REQ-030 While rst_n=0 at a rising clk edge, all cells SHALL become invalid with tid=0 and info=0.
REQ-031 Under the same reset condition, count=0, empty_flag=1, full_flag=0, schden_flag=0, out_tid=0 and info_out=0.
REQ-032 Reset SHALL override all same-cycle enq, deq, rem and tick requests.
REQ-033 Reset asserted mid-operation SHALL discard all content, with no partial shifts.

Verification
REQ-034 Reset, then enqueue tids 5, 2, 7, 2 (info 10, 20, 30, 40) -> cells read 2/20, 2/40, 5/10, 7/30, with out_tid=2, info_out=20, count=4.
REQ-035 Fill DEPTH=8 entries, then assert enq with tid 0 -> request dropped, full_flag=1, contents unchanged; then enq+deq together -> count stays 8 and the new tid is placed sorted.
REQ-036 Queue {1/3, 4/0}, then tick for 4 cycles -> infos read 2/0, 1/0, 0/0, 0/0, never wrapping to all-ones.
REQ-037 Queue {1, 3, 3, 6}, then rem with rem_tid=3 and deq asserted in the same cycle -> the first 3 is removed, the deq is ignored, and the result is {1, 3, 6}; rem with rem_tid=9 -> no change.
REQ-038 Non-empty queue with que_act=1 and que_blk=0 -> schden_flag=1 on the next edge; que_blk=1 -> 0; rst_n=0 during an enq -> empty_flag=1, count=0, and no insert occurs.
